// File: rtl/fetch_pc_unit_pkg.sv
// Purpose : shared types and constants for the PC / instruction-fetch stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int WORD_W = 32;

   // Sequential step applied by the external PC+4 adder.
   localparam logic [WORD_W-1:0] PC_INC           = 32'd4;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Purpose : instruction-memory req/ack bus plus the decode valid/ready bus.
// Latency : n/a (wiring only).
// Backpressure: decode holds instr_out by keeping ready_in low.
// Ports   : imem_req_out/imem_addr_out -> memory, imem_ack_in/imem_data_in <- memory,
//           instr_out/instr_valid_out -> decode, ready_in <- decode.
//           master = fetch unit, slave = memory/decode side.
interface fetch_pc_unit_if;
   import fetch_pkg::*;

   logic              imem_req_out;
   logic [WORD_W-1:0] imem_addr_out;
   logic              imem_ack_in;
   logic [WORD_W-1:0] imem_data_in;
   logic [WORD_W-1:0] instr_out;
   logic              instr_valid_out;
   logic              ready_in;

   modport master (
      output imem_req_out, imem_addr_out, instr_out, instr_valid_out,
      input  imem_ack_in, imem_data_in, ready_in
   );

   modport slave (
      input  imem_req_out, imem_addr_out, instr_out, instr_valid_out,
      output imem_ack_in, imem_data_in, ready_in
   );

endinterface

// File: rtl/fetch_pc_unit_pc_next_mux.sv
// Purpose : next-PC select (jump > branch > sequential) with alignment check.
// Latency : combinational.
// Backpressure: none; caller decides when the result is consumed.
// Ports   : pc_plus4_in, branch_taken_in/branch_target_in, jump_in/jump_target_in in;
//           next_pc_out (bits [1:0] cleared), misalign_out (selected target unaligned).
module pc_next_mux
   import fetch_pkg::*;
(
   input  logic [WORD_W-1:0] pc_plus4_in,
   input  logic              branch_taken_in,
   input  logic [WORD_W-1:0] branch_target_in,
   input  logic              jump_in,
   input  logic [WORD_W-1:0] jump_target_in,
   output logic [WORD_W-1:0] next_pc_out,
   output logic              misalign_out
);

   logic [WORD_W-1:0] sel;

   always_comb begin
      sel = pc_plus4_in;
      if (jump_in) begin
         sel = jump_target_in;
      end else if (branch_taken_in) begin
         sel = branch_target_in;
      end
   end

   // The PC always stays word-aligned; an unaligned target is flagged, not trapped.
   assign next_pc_out  = {sel[WORD_W-1:2], 2'b00};
   assign misalign_out = |sel[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Purpose : architectural PC plus fetch FSM (IDLE -> REQ -> VALID -> REQ ...).
// Latency : 1 cycle from req to instr_valid_out on a zero-wait ack; best 1 instr / 2 cycles.
// Backpressure: ready_in=0 in VALID holds PC, instruction and redirect decision.
// Ports   : clk_in, rst_n_in (sync, active-low); pc_out -> external adder, pc_plus4_in <- adder;
//           branch/jump redirect inputs; misalign_out sticky flag; bus = memory/decode interface.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic              clk_in,
   input  logic              rst_n_in,
   output logic [WORD_W-1:0] pc_out,
   input  logic [WORD_W-1:0] pc_plus4_in,
   input  logic              branch_taken_in,
   input  logic [WORD_W-1:0] branch_target_in,
   input  logic              jump_in,
   input  logic [WORD_W-1:0] jump_target_in,
   output logic              misalign_out,
   fetch_pc_unit_if.master   bus
);

   localparam logic [WORD_W-1:0] RESET_PC_W = {RESET_PC[WORD_W-1:2], 2'b00};

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              misalign_q, misalign_d;

   logic [WORD_W-1:0] next_pc;
   logic              next_misalign;

   pc_next_mux u_pc_next_mux (
      .pc_plus4_in      (pc_plus4_in),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in),
      .jump_in          (jump_in),
      .jump_target_in   (jump_target_in),
      .next_pc_out      (next_pc),
      .misalign_out     (next_misalign)
   );

   // State register; reset also discards any ack in the same cycle.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC_W;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         misalign_q <= misalign_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (bus.imem_ack_in) state_d = VALID;
         VALID:   if (bus.ready_in)    state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates; redirect inputs are only looked at on the accepting cycle.
   always_comb begin
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      misalign_d = misalign_q;
      if (state_q == REQ && bus.imem_ack_in) begin
         instr_d = bus.imem_data_in;
         valid_d = 1'b1;
      end
      if (state_q == VALID && bus.ready_in) begin
         pc_d       = next_pc;
         valid_d    = 1'b0;
         misalign_d = misalign_q | next_misalign;
      end
   end

   // Outputs: registered values or pure state decode.
   always_comb begin
      bus.imem_req_out    = (state_q == REQ);
      bus.imem_addr_out   = pc_q;
      bus.instr_out       = instr_q;
      bus.instr_valid_out = valid_q;
      pc_out              = pc_q;
      misalign_out        = misalign_q;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose : self-checking bench for fetch_pc_unit against a transaction-level model.
// Latency : n/a.
// Backpressure: bench drives ready_in stalls and memory wait cycles.
module tb_fetch_pc_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_in;
   logic        branch_taken_in;
   logic [31:0] branch_target_in;
   logic        jump_in;
   logic [31:0] jump_target_in;
   logic        misalign_out;

   fetch_pc_unit_if bus ();

   fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .pc_out           (pc_out),
      .pc_plus4_in      (pc_plus4_in),
      .branch_taken_in  (branch_taken_in),
      .branch_target_in (branch_target_in),
      .jump_in          (jump_in),
      .jump_target_in   (jump_target_in),
      .misalign_out     (misalign_out),
      .bus              (bus)
   );

   always #5 clk_in = ~clk_in;

   // External PC+4 adder and a memory whose contents are a fixed function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign pc_plus4_in      = pc_out + PC_INC;
   assign bus.imem_data_in = mem_word(bus.imem_addr_out);

   // Reference model: what the fetch stage should be presenting right now.
   logic [31:0] m_pc, m_instr;
   logic        m_req, m_valid, m_mis;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " pc_out"},        pc_out,                      m_pc);
      chk({tag, " imem_addr"},     bus.imem_addr_out,           m_pc);
      chk({tag, " imem_req"},      {31'd0, bus.imem_req_out},   {31'd0, m_req});
      chk({tag, " instr_out"},     bus.instr_out,               m_instr);
      chk({tag, " instr_valid"},   {31'd0, bus.instr_valid_out}, {31'd0, m_valid});
      chk({tag, " misalign"},      {31'd0, misalign_out},       {31'd0, m_mis});
   endtask

   // Randomise inputs that the unit must ignore in the current cycle.
   task automatic rand_dontcare();
      branch_taken_in  = ($urandom % 2) == 1;
      jump_in          = ($urandom % 2) == 1;
      branch_target_in = $urandom;
      jump_target_in   = $urandom;
      bus.ready_in     = ($urandom % 2) == 1;
   endtask

   task automatic model_reset();
      m_pc    = RST_PC;
      m_instr = 32'd0;
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_mis   = 1'b0;
   endtask

   // Reset lands the unit in its idle cycle; release then starts the first request.
   task automatic start_after_reset(input string tag);
      rst_n_in = 1'b1;
      rand_dontcare();
      bus.imem_ack_in = ($urandom % 2) == 1;
      tick();
      m_req = 1'b1;
      check_all(tag);
   endtask

   task automatic mem_wait(input int n);
      for (int i = 0; i < n; i++) begin
         rand_dontcare();
         bus.imem_ack_in = 1'b0;
         tick();
         check_all("wait");
      end
   endtask

   task automatic mem_ack();
      rand_dontcare();
      bus.imem_ack_in = 1'b1;
      tick();
      m_instr = mem_word(m_pc);
      m_valid = 1'b1;
      m_req   = 1'b0;
      check_all("ack");
      bus.imem_ack_in = 1'b0;
   endtask

   task automatic stall(input int n);
      for (int i = 0; i < n; i++) begin
         rand_dontcare();
         bus.ready_in    = 1'b0;
         bus.imem_ack_in = ($urandom % 2) == 1;
         tick();
         check_all("stall");
      end
   endtask

   task automatic accept(input logic j, input logic b, input logic [31:0] jt, input logic [31:0] bt,
                         input string tag);
      logic [31:0] tgt;
      bus.ready_in     = 1'b1;
      bus.imem_ack_in  = ($urandom % 2) == 1;
      jump_in          = j;
      branch_taken_in  = b;
      jump_target_in   = jt;
      branch_target_in = bt;
      tgt = j ? jt : (b ? bt : m_pc + PC_INC);
      tick();
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc    = tgt - (tgt % 4);
      m_valid = 1'b0;
      m_req   = 1'b1;
      check_all(tag);
      bus.ready_in = 1'b0;
      jump_in = 1'b0;
      branch_taken_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with ack already high: first request follows one idle cycle.
      rst_n_in = 1'b0;
      rand_dontcare();
      bus.imem_ack_in = 1'b1;
      tick();
      tick();
      model_reset();
      check_all("reset");
      start_after_reset("first_req");
      mem_ack();

      // Stall three cycles with random redirect noise, then sequential accept.
      stall(3);
      accept(1'b0, 1'b0, 32'h0, 32'h0, "seq");
      chk("seq pc value", pc_out, 32'h0040_0004);

      // Jump beats branch; branch alone redirects.
      mem_ack();
      accept(1'b1, 1'b1, 32'h0040_1000, 32'h0040_0200, "prio_jump");
      chk("prio_jump pc value", pc_out, 32'h0040_1000);
      mem_ack();
      accept(1'b0, 1'b1, 32'h1111_1110, 32'h0040_0200, "prio_branch");
      chk("prio_branch pc value", pc_out, 32'h0040_0200);

      // Slow memory, then wrap-around at the top of the address space.
      mem_wait(4);
      mem_ack();
      accept(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, "to_top");
      mem_ack();
      accept(1'b0, 1'b0, 32'h0, 32'h0, "wrap");
      chk("wrap pc value", pc_out, 32'h0000_0000);
      chk("wrap misalign", {31'd0, misalign_out}, 32'd0);

      // Unaligned branch target: PC loads aligned address, flag sticks.
      mem_ack();
      accept(1'b0, 1'b1, 32'h0, 32'h0040_0006, "misalign");
      chk("misalign pc value", pc_out, 32'h0040_0004);
      mem_ack();
      stall(1);
      accept(1'b0, 1'b0, 32'h0, 32'h0, "sticky");
      chk("sticky flag", {31'd0, misalign_out}, 32'd1);

      // Reset during a request with ack in the same cycle: ack is dropped.
      rst_n_in = 1'b0;
      bus.imem_ack_in = 1'b1;
      tick();
      model_reset();
      check_all("rst_mid");
      start_after_reset("rst_mid_restart");
      mem_wait(1);

      // Random traffic against the model.
      for (int t = 0; t < 40; t++) begin
         logic        j, b;
         logic [31:0] jt, bt;
         mem_wait($urandom_range(0, 3));
         mem_ack();
         stall($urandom_range(0, 3));
         j  = ($urandom % 4) == 0;
         b  = ($urandom % 3) == 0;
         jt = $urandom;
         bt = $urandom;
         if (($urandom % 8) != 0) jt = jt & 32'hFFFF_FFFC;
         if (($urandom % 8) != 0) bt = bt & 32'hFFFF_FFFC;
         accept(j, b, jt, bt, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-fetch stage of the single-cycle MIPS datapath. Holds the architectural PC, drives it to the PC+4 `Adder`, and consumes that adder's sum together with the branch and jump targets to select the next PC. Fetches each instruction through a req/ack handshake with instruction memory and presents it to decode with a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  synchronous active-low reset.
- `pc_out`  out  32  current PC; drives `Adder.data1_in`, with `data2_in` tied to 4.
- `pc_plus4_in`  in  32  `Adder.data_out`, equal to `pc_out + 4` mod 2^32.
- `branch_taken_in`  in  1  decode/ALU resolved that the branch is taken.
- `branch_target_in`  in  32  branch target address.
- `jump_in`  in  1  jump instruction.
- `jump_target_in`  in  32  jump target address.
- `imem_req_out`  out  1  fetch request.
- `imem_addr_out`  out  32  fetch address; always equal to `pc_out`.
- `imem_ack_in`  in  1  memory returns data this cycle.
- `imem_data_in`  in  32  instruction word; valid when `imem_ack_in` is 1.
- `instr_out`  out  32  registered instruction.
- `instr_valid_out`  out  1  `instr_out` holds an unconsumed instruction.
- `ready_in`  in  1  decode accepts `instr_out`; 0 means stall.
- `misalign_out`  out  1  sticky error flag for a non-word-aligned redirect target.

## Operation
- **Reset values:**
  - `pc_out=RESET_PC`
  - `imem_req_out=0`
  - `instr_out=0`
  - `instr_valid_out=0`
  - `misalign_out=0`
  - state is IDLE.
- **FSM states:** IDLE, REQ, VALID.
- **IDLE:** always moves to REQ on the next edge. There are no outputs other than the reset values.
- **REQ:**
  - `imem_req_out=1`; `pc_out` and `imem_addr_out` are held stable.
  - On `imem_ack_in=1`: capture `imem_data_in` into `instr_out`, set `instr_valid_out=1`, and go to VALID.
  - With no ack, stay in REQ indefinitely.
- **VALID:**
  - `imem_req_out=0`.
  - With `ready_in=0`: hold everything. Branch and jump inputs are ignored.
  - With `ready_in=1`: load the next PC, clear `instr_valid_out`, and go to REQ.
- **Next-PC priority:**
  1. `jump_in` selects `jump_target_in`.
  2. Otherwise `branch_taken_in` selects `branch_target_in`.
  3. Otherwise `pc_plus4_in` is selected.
- **Misaligned redirect:** if the selected target has bits [1:0]≠0, `misalign_out` sets (sticky until reset). The PC still loads the target with bits [1:0] forced to 00.
- **Wrap-around:** at PC 32'hFFFF_FFFC, sequential flow yields 32'h0000_0000 with no flag.
- Redirect inputs are sampled only in the VALID cycle where `ready_in=1`. They are don't-care in all other cycles.
- **Reset mid-operation:** reset wins over every other event. An ack arriving in the same cycle as reset is discarded. The next state is IDLE.
- `instr_out` keeps its last value when `instr_valid_out=0`.

## Timing
- Reset is released at edge E0.
- IDLE occupies cycle E0–E1. REQ is first asserted after E1.
- **Zero-wait memory:** ack arrives in the first REQ cycle, `instr_valid_out=1` after the next edge, so 1 cycle from req to valid.
- **Throughput:** at best 1 instruction per 2 cycles (REQ + VALID).
- Each memory wait cycle adds 1 cycle; each stall cycle adds 1 cycle.
- `pc_out` changes only on the edge that leaves VALID with `ready_in=1`. It is therefore stable for the whole REQ phase.
- All outputs are registered or decoded from state. There is no combinational path from `imem_*` or `ready_in` to any output.

## Structure
- **Package `fetch_pkg`:**
  - state enum {IDLE, REQ, VALID}
  - `PC_INC = 32'd4`
  - default `RESET_PC`
  - 32-bit word-width constant.
- **Sub-module `pc_next_mux`:** combinational jump/branch/sequential priority select plus the alignment check. Outputs are the next PC (bits [1:0] cleared) and a misalign pulse.
- `Adder` is instantiated alongside this block at the datapath level, not inside it.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0x0040_0000; release reset with ack tied to 1. Expect `imem_req_out` after 1 idle cycle with addr 0x0040_0000. `instr_valid_out` rises one cycle later; `instr_out` equals the memory word.
- **Sequential flow and stall:** `ready_in`=0 for 3 cycles in VALID. Expect `pc_out` and `instr_out` held, and `branch_taken_in` pulses ignored. Then `ready_in`=1 gives `pc_out`=0x0040_0004.
- **Priority:** assert `jump_in` (target 0x0040_1000) and `branch_taken_in` (target 0x0040_0200) in the same accepted cycle. Expect `pc_out`=0x0040_1000. With only the branch asserted, expect 0x0040_0200.
- **Memory wait and wrap:**
  - Ack delayed 4 cycles: expect addr stable and req held throughout.
  - PC 0xFFFF_FFFC sequential: expect next PC 0x0000_0000 and `misalign_out`=0.
- **Misalign:** branch target 0x0040_0006. Expect `pc_out`=0x0040_0004 and `misalign_out`=1, staying high until reset.
- **Reset mid-fetch:** drive reset low in REQ with ack=1 in the same cycle. Expect all outputs at reset values next cycle and `instr_valid_out` never asserted.
